// File: rtl/ahb_slave_port_stage_pkg.sv
// ahb_slave_port_stage_pkg: shared encodings and field widths for the AHB slave port stage
package ahb_slave_port_stage_pkg;
    localparam int TRANS_W = 2;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 3;
    localparam int PROT_W  = 4;
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;
    typedef enum logic [3:0] {
        MASTER_NONE = 4'b0000,
        MASTER_0    = 4'b0001,
        MASTER_1    = 4'b0010,
        MASTER_2    = 4'b0100,
        MASTER_3    = 4'b1000
    } master_t;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2,
        ST_BLOCK
    } state_t;
    // Isolates the lowest set bit so an illegal multi-hot grant still selects one master
    function automatic logic [3:0] lowest_one(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction
endpackage

// File: rtl/ahb_master_field_mux.sv
// ahb_master_field_mux: one-hot select 4:1 mux of a packed per-master field
module ahb_master_field_mux #(
    parameter int W = 32
) (
    input  logic [3:0]     sel,
    input  logic [4*W-1:0] din,
    output logic [W-1:0]   dout
);
    always_comb begin
        dout = '0;
        for (int i = 0; i < 4; i++) dout = dout | (din[i*W +: W] & {W{sel[i]}});
    end
endmodule

// File: rtl/ahb_slave_port_stage.sv
// ahb_slave_port_stage: per-slave address mux, data-phase owner tracking and response routing.
// Optional wait-state timeout with a two-cycle ERROR is enabled by SLAVE_PORT_TIMEOUT_EN.
module ahb_slave_port_stage
    import ahb_slave_port_stage_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [3:0]           MASTERADDRINPROG,
    output logic                 ADDRPHEND,
    input  logic [4*ADDR_W-1:0]  M_HADDR,
    input  logic [4*TRANS_W-1:0] M_HTRANS,
    input  logic [3:0]           M_HWRITE,
    input  logic [4*SIZE_W-1:0]  M_HSIZE,
    input  logic [4*BURST_W-1:0] M_HBURST,
    input  logic [4*PROT_W-1:0]  M_HPROT,
    input  logic [3:0]           M_HMASTLOCK,
    input  logic [4*DATA_W-1:0]  M_HWDATA,
    output logic [3:0]           M_HREADY,
    output logic [3:0]           M_HRESP,
    output logic [DATA_W-1:0]    M_HRDATA,
    output logic                 S_HSEL,
    output logic [ADDR_W-1:0]    S_HADDR,
    output logic [TRANS_W-1:0]   S_HTRANS,
    output logic                 S_HWRITE,
    output logic [SIZE_W-1:0]    S_HSIZE,
    output logic [BURST_W-1:0]   S_HBURST,
    output logic [PROT_W-1:0]    S_HPROT,
    output logic                 S_HMASTLOCK,
    output logic [DATA_W-1:0]    S_HWDATA,
    output logic                 S_HREADY,
    input  logic                 S_HREADYOUT,
    input  logic                 S_HRESP,
    input  logic [DATA_W-1:0]    S_HRDATA
);
    state_t     state, state_nxt;
    logic [3:0] addr_sel, data_owner, owner_nxt;
    logic       timeout_hit;
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
        $error("TIMEOUT_CYC must be within 1..65535");
    end
    assign addr_sel = (state == ST_BLOCK) ? MASTER_NONE : lowest_one(MASTERADDRINPROG);
    assign S_HSEL   = |addr_sel;
    assign M_HRDATA = S_HRDATA;
    ahb_master_field_mux #(.W(ADDR_W))  u_haddr  (.sel(addr_sel),   .din(M_HADDR),     .dout(S_HADDR));
    ahb_master_field_mux #(.W(TRANS_W)) u_htrans (.sel(addr_sel),   .din(M_HTRANS),    .dout(S_HTRANS));
    ahb_master_field_mux #(.W(1))       u_hwrite (.sel(addr_sel),   .din(M_HWRITE),    .dout(S_HWRITE));
    ahb_master_field_mux #(.W(SIZE_W))  u_hsize  (.sel(addr_sel),   .din(M_HSIZE),     .dout(S_HSIZE));
    ahb_master_field_mux #(.W(BURST_W)) u_hburst (.sel(addr_sel),   .din(M_HBURST),    .dout(S_HBURST));
    ahb_master_field_mux #(.W(PROT_W))  u_hprot  (.sel(addr_sel),   .din(M_HPROT),     .dout(S_HPROT));
    ahb_master_field_mux #(.W(1))       u_hlock  (.sel(addr_sel),   .din(M_HMASTLOCK), .dout(S_HMASTLOCK));
    ahb_master_field_mux #(.W(DATA_W))  u_hwdata (.sel(data_owner), .din(M_HWDATA),    .dout(S_HWDATA));
`ifdef SLAVE_PORT_TIMEOUT_EN
    logic [15:0] wait_cnt;
    always_ff @(posedge HCLK) begin
        if (HRESET) wait_cnt <= '0;
        else wait_cnt <= (state == ST_DATA && !S_HREADYOUT) ? wait_cnt + 16'd1 : 16'd0;
    end
    // Fires on the stalled cycle that brings the count up to the limit
    assign timeout_hit = !S_HREADYOUT && (wait_cnt == 16'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            data_owner <= MASTER_NONE;
        end else begin
            state      <= state_nxt;
            data_owner <= owner_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        owner_nxt = data_owner;
        if (state == ST_DATA && timeout_hit) state_nxt = ST_ERR1;
        else if (state == ST_ERR1) state_nxt = ST_ERR2;
        else if (state == ST_ERR2) begin
            state_nxt = ST_BLOCK;
            owner_nxt = MASTER_NONE;
        end else if (state == ST_BLOCK) state_nxt = S_HREADYOUT ? ST_IDLE : ST_BLOCK;
        else if (ADDRPHEND) begin
            owner_nxt = S_HTRANS[1] ? addr_sel : MASTER_NONE;
            state_nxt = |owner_nxt ? ST_DATA : ST_IDLE;
        end
    end
    always_comb begin
        S_HREADY  = (state == ST_DATA) ? S_HREADYOUT : 1'b1;
        ADDRPHEND = (state == ST_ERR1 || state == ST_BLOCK) ? 1'b0 : S_HREADY;
        M_HREADY  = (state == ST_ERR1) ? 4'b0000 : data_owner & {4{S_HREADY}};
        M_HRESP   = data_owner & {4{(state == ST_ERR1 || state == ST_ERR2) ? 1'b1 : S_HRESP}};
    end
endmodule

// File: tb/tb_ahb_slave_port_stage.sv
// tb_ahb_slave_port_stage: directed checks of address muxing, owner tracking and ready/response routing.
// Timeout scenario runs only when SLAVE_PORT_TIMEOUT_EN is defined (TIMEOUT_CYC = 4).
module tb_ahb_slave_port_stage;
    logic         HCLK = 1'b0;
    logic         HRESET;
    logic [3:0]   MASTERADDRINPROG;
    logic         ADDRPHEND;
    logic [127:0] M_HADDR;
    logic [7:0]   M_HTRANS;
    logic [3:0]   M_HWRITE;
    logic [11:0]  M_HSIZE;
    logic [11:0]  M_HBURST;
    logic [15:0]  M_HPROT;
    logic [3:0]   M_HMASTLOCK;
    logic [127:0] M_HWDATA;
    logic [3:0]   M_HREADY;
    logic [3:0]   M_HRESP;
    logic [31:0]  M_HRDATA;
    logic         S_HSEL;
    logic [31:0]  S_HADDR;
    logic [1:0]   S_HTRANS;
    logic         S_HWRITE;
    logic [2:0]   S_HSIZE;
    logic [2:0]   S_HBURST;
    logic [3:0]   S_HPROT;
    logic         S_HMASTLOCK;
    logic [31:0]  S_HWDATA;
    logic         S_HREADY;
    logic         S_HREADYOUT;
    logic         S_HRESP;
    logic [31:0]  S_HRDATA;
    int pass = 0;
    int total = 0;

    always #5 HCLK = ~HCLK;

    ahb_slave_port_stage #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .MASTERADDRINPROG(MASTERADDRINPROG), .ADDRPHEND(ADDRPHEND),
        .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
        .M_HBURST(M_HBURST), .M_HPROT(M_HPROT), .M_HMASTLOCK(M_HMASTLOCK), .M_HWDATA(M_HWDATA),
        .M_HREADY(M_HREADY), .M_HRESP(M_HRESP), .M_HRDATA(M_HRDATA),
        .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
        .S_HSIZE(S_HSIZE), .S_HBURST(S_HBURST), .S_HPROT(S_HPROT), .S_HMASTLOCK(S_HMASTLOCK),
        .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
        .S_HRDATA(S_HRDATA)
    );

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        step();
        step();
        #1;
        total++; if (S_HREADY !== 1'b1) $display("FAIL reset_s_hready: got %b want 1", S_HREADY); else pass++;
        total++; if (ADDRPHEND !== 1'b1) $display("FAIL reset_addrphend: got %b want 1", ADDRPHEND); else pass++;
        total++; if (M_HREADY !== 4'b0000) $display("FAIL reset_m_hready: got %b want 0000", M_HREADY); else pass++;
        total++; if (M_HRESP !== 4'b0000) $display("FAIL reset_m_hresp: got %b want 0000", M_HRESP); else pass++;
        total++; if ({S_HSEL, S_HADDR, S_HTRANS, S_HWRITE, S_HWDATA} !== 68'd0)
            $display("FAIL reset_slave_bus: got sel=%b addr=%h trans=%b wr=%b wdata=%h want all zero", S_HSEL, S_HADDR, S_HTRANS, S_HWRITE, S_HWDATA); else pass++;
        HRESET = 1'b0;
    endtask

    task automatic test_single_write();
        step();
        MASTERADDRINPROG = 4'b0010;
        S_HREADYOUT = 1'b1;
        #1;
        total++; if (S_HSEL !== 1'b1) $display("FAIL single_hsel: got %b want 1", S_HSEL); else pass++;
        total++; if (S_HADDR !== 32'h0000_0040) $display("FAIL single_haddr: got %h want 00000040", S_HADDR); else pass++;
        total++; if ({S_HTRANS, S_HWRITE, S_HSIZE, S_HBURST, S_HPROT, S_HMASTLOCK} !== {2'b10, 1'b1, 3'd2, 3'd3, 4'h2, 1'b1})
            $display("FAIL single_ctrl: got trans=%b wr=%b size=%0d burst=%0d prot=%h lock=%b want 10 1 2 3 2 1", S_HTRANS, S_HWRITE, S_HSIZE, S_HBURST, S_HPROT, S_HMASTLOCK); else pass++;
        total++; if (ADDRPHEND !== 1'b1) $display("FAIL single_addrphend: got %b want 1", ADDRPHEND); else pass++;
        step();
        MASTERADDRINPROG = 4'b0000;
        #1;
        total++; if (S_HWDATA !== 32'hD111_1111) $display("FAIL single_hwdata: got %h want d1111111", S_HWDATA); else pass++;
        total++; if (M_HREADY !== 4'b0010) $display("FAIL single_m_hready: got %b want 0010", M_HREADY); else pass++;
        total++; if ({S_HSEL, S_HTRANS, S_HADDR} !== 35'd0) $display("FAIL single_idle_bus: got sel=%b trans=%b addr=%h want 0 00 0", S_HSEL, S_HTRANS, S_HADDR); else pass++;
        step();
        #1;
        total++; if (M_HREADY !== 4'b0000) $display("FAIL single_done: got %b want 0000", M_HREADY); else pass++;
    endtask

    task automatic test_wait_states();
        step();
        MASTERADDRINPROG = 4'b0100;
        #1;
        total++; if ({S_HADDR, S_HWRITE} !== {32'h2222_0200, 1'b0}) $display("FAIL wait_addr: got %h wr=%b want 22220200 0", S_HADDR, S_HWRITE); else pass++;
        step();
        MASTERADDRINPROG = 4'b0000;
        S_HREADYOUT = 1'b0;
        S_HRDATA = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if ({ADDRPHEND, S_HREADY, M_HREADY} !== 6'b0) $display("FAIL wait_stall%0d: got ape=%b srdy=%b mrdy=%b want 0 0 0000", i, ADDRPHEND, S_HREADY, M_HREADY); else pass++;
            step();
        end
        S_HREADYOUT = 1'b1;
        S_HRESP = 1'b1;
        #1;
        total++; if (M_HREADY !== 4'b0100) $display("FAIL wait_m_hready: got %b want 0100", M_HREADY); else pass++;
        total++; if (M_HRESP !== 4'b0100) $display("FAIL wait_m_hresp: got %b want 0100", M_HRESP); else pass++;
        total++; if (M_HRDATA !== 32'hCAFE_F00D) $display("FAIL wait_hrdata: got %h want cafef00d", M_HRDATA); else pass++;
        total++; if (ADDRPHEND !== 1'b1) $display("FAIL wait_addrphend: got %b want 1", ADDRPHEND); else pass++;
        step();
        S_HRESP = 1'b0;
    endtask

    task automatic test_back_to_back();
        step();
        MASTERADDRINPROG = 4'b0001;
        #1;
        total++; if (S_HADDR !== 32'h1111_0100) $display("FAIL b2b_addr0: got %h want 11110100", S_HADDR); else pass++;
        step();
        MASTERADDRINPROG = 4'b1000;
        #1;
        total++; if (S_HADDR !== 32'h3333_0300) $display("FAIL b2b_addr3: got %h want 33330300", S_HADDR); else pass++;
        total++; if ({M_HREADY, S_HWDATA} !== {4'b0001, 32'hD000_0000}) $display("FAIL b2b_owner0: got rdy=%b wdata=%h want 0001 d0000000", M_HREADY, S_HWDATA); else pass++;
        step();
        MASTERADDRINPROG = 4'b0000;
        #1;
        total++; if ({M_HREADY, S_HWDATA} !== {4'b1000, 32'hD333_3333}) $display("FAIL b2b_owner3: got rdy=%b wdata=%h want 1000 d3333333", M_HREADY, S_HWDATA); else pass++;
        step();
        #1;
        total++; if (M_HREADY !== 4'b0000) $display("FAIL b2b_done: got %b want 0000", M_HREADY); else pass++;
    endtask

    task automatic test_idle_transfer();
        step();
        MASTERADDRINPROG = 4'b0010;
        M_HTRANS[3:2] = 2'b00;
        #1;
        total++; if ({S_HSEL, S_HTRANS} !== 3'b100) $display("FAIL idle_bus: got sel=%b trans=%b want 1 00", S_HSEL, S_HTRANS); else pass++;
        step();
        MASTERADDRINPROG = 4'b0000;
        M_HTRANS[3:2] = 2'b10;
        #1;
        total++; if ({M_HREADY, S_HWDATA} !== 36'd0) $display("FAIL idle_owner: got rdy=%b wdata=%h want 0000 0", M_HREADY, S_HWDATA); else pass++;
    endtask

    task automatic test_multi_hot();
        step();
        MASTERADDRINPROG = 4'b1010;
        #1;
        total++; if (S_HADDR !== 32'h0000_0040) $display("FAIL multihot_addr: got %h want 00000040", S_HADDR); else pass++;
        step();
        MASTERADDRINPROG = 4'b0000;
        #1;
        total++; if (M_HREADY !== 4'b0010) $display("FAIL multihot_owner: got %b want 0010", M_HREADY); else pass++;
    endtask

    task automatic test_reset_mid();
        step();
        MASTERADDRINPROG = 4'b0100;
        step();
        MASTERADDRINPROG = 4'b0000;
        S_HREADYOUT = 1'b0;
        S_HRESP = 1'b1;
        #1;
        total++; if (S_HREADY !== 1'b0) $display("FAIL rstmid_stall: got %b want 0", S_HREADY); else pass++;
        HRESET = 1'b1;
        step();
        step();
        #1;
        total++; if ({S_HREADY, M_HREADY, M_HRESP} !== 9'b1_0000_0000) $display("FAIL rstmid_clear: got srdy=%b mrdy=%b mresp=%b want 1 0000 0000", S_HREADY, M_HREADY, M_HRESP); else pass++;
        HRESET = 1'b0;
        S_HREADYOUT = 1'b1;
        S_HRESP = 1'b0;
        step();
        #1;
        total++; if ({ADDRPHEND, M_HREADY} !== 5'b1_0000) $display("FAIL rstmid_after: got ape=%b mrdy=%b want 1 0000", ADDRPHEND, M_HREADY); else pass++;
    endtask

`ifdef SLAVE_PORT_TIMEOUT_EN
    task automatic test_timeout();
        step();
        MASTERADDRINPROG = 4'b0001;
        step();
        MASTERADDRINPROG = 4'b0000;
        S_HREADYOUT = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            total++; if ({M_HREADY, M_HRESP} !== 8'd0) $display("FAIL tmo_wait%0d: got rdy=%b resp=%b want 0000 0000", i, M_HREADY, M_HRESP); else pass++;
            step();
        end
        #1;
        total++; if ({M_HRESP, M_HREADY, ADDRPHEND} !== {4'b0001, 4'b0000, 1'b0}) $display("FAIL tmo_err1: got resp=%b rdy=%b ape=%b want 0001 0000 0", M_HRESP, M_HREADY, ADDRPHEND); else pass++;
        step();
        #1;
        total++; if ({M_HRESP, M_HREADY} !== {4'b0001, 4'b0001}) $display("FAIL tmo_err2: got resp=%b rdy=%b want 0001 0001", M_HRESP, M_HREADY); else pass++;
        step();
        MASTERADDRINPROG = 4'b0010;
        #1;
        total++; if ({ADDRPHEND, S_HSEL, M_HRESP} !== 6'd0) $display("FAIL tmo_block: got ape=%b sel=%b resp=%b want 0 0 0000", ADDRPHEND, S_HSEL, M_HRESP); else pass++;
        step();
        S_HREADYOUT = 1'b1;
        #1;
        total++; if (ADDRPHEND !== 1'b0) $display("FAIL tmo_block_release: got %b want 0", ADDRPHEND); else pass++;
        step();
        #1;
        total++; if ({ADDRPHEND, S_HSEL} !== 2'b11) $display("FAIL tmo_idle: got ape=%b sel=%b want 1 1", ADDRPHEND, S_HSEL); else pass++;
        MASTERADDRINPROG = 4'b0000;
        step();
    endtask
`endif

    initial begin
        HRESET = 1'b1;
        MASTERADDRINPROG = 4'b0000;
        M_HADDR = {32'h3333_0300, 32'h2222_0200, 32'h0000_0040, 32'h1111_0100};
        M_HWDATA = {32'hD333_3333, 32'hD222_2222, 32'hD111_1111, 32'hD000_0000};
        M_HTRANS = 8'b10_10_10_10;
        M_HWRITE = 4'b1011;
        M_HSIZE = {3'd2, 3'd1, 3'd2, 3'd0};
        M_HBURST = {3'd1, 3'd0, 3'd3, 3'd0};
        M_HPROT = 16'h4321;
        M_HMASTLOCK = 4'b0010;
        S_HREADYOUT = 1'b1;
        S_HRESP = 1'b0;
        S_HRDATA = 32'h0;
        test_reset();
        test_single_write();
        test_wait_states();
        test_back_to_back();
        test_idle_transfer();
        test_multi_hot();
        test_reset_mid();
`ifdef SLAVE_PORT_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
